// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: two debounced buttons drive a four-state
// run/lap/pause FSM that commands the counter and the lap display register.
module stopwatch_ctrl #(
   parameter int DEB_CYCLES = 500000
) (
   input  logic       NEclk,
   input  logic       reset,
   input  logic       btn_ss,
   input  logic       btn_lap,
   output logic       Enable,
   output logic       cnt_clear,
   output logic       freeze,
   output logic       freeze_load,
   output logic [3:0] lap_count,
   output logic [1:0] state
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      LAP   = 2'b10,
      PAUSE = 2'b11
   } state_t;

   logic [1:0] btn_raw;
   logic [1:0] press;
   logic       ss_p;
   logic       lap_p;

   assign btn_raw = {btn_lap, btn_ss};

   // Bit 0 is start/stop, bit 1 is lap/clear; each gets its own synchronizer,
   // debouncer and rising-edge detector.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         logic          sync1_reg;
         logic          sync2_reg;
         logic          deb_reg;
         logic          deb_d_reg;
         logic          press_reg;
         logic [CW-1:0] cnt_reg;

         always_ff @(negedge NEclk) begin
            if (reset) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               deb_reg   <= 1'b0;
               deb_d_reg <= 1'b0;
               press_reg <= 1'b0;
               cnt_reg   <= '0;
            end else begin
               sync1_reg <= btn_raw[gi];
               sync2_reg <= sync1_reg;
               deb_d_reg <= deb_reg;
               press_reg <= deb_reg & ~deb_d_reg;
               if (sync2_reg == deb_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == CNT_LAST) begin
                  deb_reg <= sync2_reg;
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
         end

         assign press[gi] = press_reg;
      end
   endgenerate

   assign ss_p  = press[0];
   assign lap_p = press[1];

   state_t     state_reg;
   state_t     state_next;
   logic [3:0] lap_count_reg;
   logic       freeze_load_reg;

   always_ff @(negedge NEclk) begin
      if (reset) begin
         state_reg       <= IDLE;
         lap_count_reg   <= 4'd0;
         freeze_load_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         freeze_load_reg <= (state_reg == RUN) && (state_next == LAP);
         if (state_next == IDLE) begin
            lap_count_reg <= 4'd0;
         end else if ((state_reg == RUN) && (state_next == LAP)) begin
            lap_count_reg <= lap_count_reg + 4'd1;
         end
      end
   end

   // Start/stop always wins over lap when both fire in the same cycle.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (ss_p) state_next = RUN;
         end
         RUN: begin
            if (ss_p)       state_next = PAUSE;
            else if (lap_p) state_next = LAP;
         end
         LAP: begin
            if (ss_p)       state_next = PAUSE;
            else if (lap_p) state_next = RUN;
         end
         PAUSE: begin
            if (ss_p)       state_next = RUN;
            else if (lap_p) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      Enable    = 1'b0;
      cnt_clear = 1'b0;
      freeze    = 1'b0;
      case (state_reg)
         IDLE:    cnt_clear = 1'b1;
         RUN:     Enable    = 1'b1;
         LAP: begin
            Enable = 1'b1;
            freeze = 1'b1;
         end
         PAUSE:   Enable    = 1'b0;
         default: cnt_clear = 1'b1;
      endcase
   end

   assign freeze_load = freeze_load_reg;
   assign lap_count   = lap_count_reg;
   assign state       = state_reg;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL provide parameter DEB_CYCLES, default 500000, giving the number of consecutive stable samples required to accept a button level change (10 ms at 50 MHz).
REQ-002 The block SHALL provide port NEclk, input, 1 bit: the single clock; all state updates on its falling edge.
REQ-003 The block SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL provide port btn_ss, input, 1 bit: raw active-high start/stop button, asynchronous to NEclk.
REQ-005 The block SHALL provide port btn_lap, input, 1 bit: raw active-high lap/clear button, asynchronous to NEclk.
REQ-006 The block SHALL provide port Enable, output, 1 bit: counting enable to the stopwatch counter.
REQ-007 The block SHALL provide port cnt_clear, output, 1 bit: level clear to the stopwatch counter.
REQ-008 The block SHALL provide port freeze, output, 1 bit: display hold; high means the display shows the captured lap value.
REQ-009 The block SHALL provide port freeze_load, output, 1 bit: one-cycle pulse commanding the display register to capture the current BCD time.
REQ-010 The block SHALL provide port lap_count, output, 4 bits: number of laps taken since the last clear.
REQ-011 The block SHALL provide port state, output, 2 bits: current FSM state encoding.

Function
REQ-012 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-013 Each button SHALL have its own debounce counter, width clog2(DEB_CYCLES+1); the counter clears whenever the synchronized level equals the debounced level.
REQ-014 The debounced level SHALL take the synchronized value when that value has differed from it for DEB_CYCLES consecutive cycles; the counter then clears.
REQ-015 A press event (ss_p, lap_p) SHALL be a one-cycle pulse on each 0->1 transition of the debounced level; 1->0 transitions produce no event.
REQ-016 A raw pulse held for fewer than DEB_CYCLES cycles SHALL produce no event.
REQ-017 The event pulse SHALL assert exactly DEB_CYCLES+2 cycles after the first edge that samples the raw level high; the state transition SHALL take effect on the following edge.
REQ-018 FSM states SHALL be IDLE=00, RUN=01, LAP=10, PAUSE=11.
REQ-019 Outputs per state SHALL be: IDLE Enable=0, cnt_clear=1, freeze=0; RUN Enable=1, cnt_clear=0, freeze=0; LAP Enable=1, cnt_clear=0, freeze=1; PAUSE Enable=0, cnt_clear=0, freeze=0.
REQ-020 IDLE transitions: ss_p -> RUN; lap_p is ignored.
REQ-021 RUN transitions: ss_p -> PAUSE; lap_p -> LAP.
REQ-022 LAP transitions: lap_p -> RUN (releases freeze); ss_p -> PAUSE.
REQ-023 PAUSE transitions: ss_p -> RUN; lap_p -> IDLE.
REQ-024 If ss_p and lap_p occur in the same cycle, ss_p SHALL take priority and lap_p SHALL be discarded.
REQ-025 freeze_load SHALL pulse high for exactly one cycle, registered and coincident with the first cycle of state LAP, on every RUN->LAP transition.
REQ-026 lap_count SHALL increment on every RUN->LAP transition, wrap 15->0, and clear to 0 on every entry to IDLE.
REQ-027 All outputs SHALL be registered or decoded directly from registered state; no combinational path from btn_* to any output.

Reset
REQ-028 While reset is high at a falling edge, the next state SHALL be IDLE, lap_count=0, freeze_load=0, both synchronizer stages=0, debounced levels=0, and debounce counters=0; this holds regardless of button levels or current state.
REQ-029 Post-reset outputs SHALL be Enable=0, cnt_clear=1, freeze=0, freeze_load=0, lap_count=0, state=00.
REQ-030 A button held high through reset release SHALL produce one press event DEB_CYCLES+2 cycles after release, with no other special handling.

Verification (DEB_CYCLES=4)
REQ-031 Reset, then btn_ss high for 10 cycles -> ss_p on cycle 6 after the first high sample; state=01, Enable=1, cnt_clear=0 on cycle 7.
REQ-032 In RUN, btn_lap glitch of 3 cycles -> no event; state stays 01 and lap_count=0.
REQ-033 In RUN, lap press -> state=10, freeze=1, freeze_load high for exactly 1 cycle, lap_count=1; a second lap press -> state=01, freeze=0, and lap_count stays 1.
REQ-034 RUN, then ss press -> PAUSE (Enable=0); then lap press -> IDLE, cnt_clear=1, lap_count=0.
REQ-035 Drive both buttons from RUN with identical timing -> state=11 (PAUSE), lap_count unchanged, no freeze_load.
REQ-036 Perform 16 RUN->LAP->RUN cycles -> lap_count wraps to 0; assert reset mid-LAP -> state=00, freeze=0, lap_count=0 on the next edge.
